lzrw1_decompressor: RTL and testbench
=====================================

# lzrw1_decompressor

Streaming LZRW1 decompressor that sits directly downstream of the compression core. It consumes the compressed byte stream (control words, literals, copy items) and rebuilds the original bytes in an internal history buffer. It drives the decompressed_byte / out_valid / finished_cycle output bus that the bench's output interface samples. There is no output backpressure; input flow control uses a ready signal.

## Interface
Parameters:
- HIST_AW, 12, history address width; depth is 2^HIST_AW bytes, and the copy offset field is 12 bits wide.

Ports:
- clock  in  1  sole clock; all logic on posedge.
- reset  in  1  asynchronous, active-low (0 = reset); deassertion is synchronous to clock.
- in_valid  in  1  in_byte is valid.
- in_byte  in  8  compressed stream byte.
- in_last  in  1  qualifies the final byte of a compressed stream.
- in_ready  out  1  block accepts in_byte this cycle; handshake = in_valid & in_ready.
- decompressed_byte  out  8  reconstructed byte.
- out_valid  out  1  decompressed_byte valid, one byte per pulse.
- finished_cycle  out  1  one-cycle pulse marking end of stream output.
- bad_item  out  1  one-cycle pulse for an illegal copy item.

## Operation
- Stream format:
  - Groups of up to 16 items, each preceded by a 16-bit control word, low byte first.
  - Control bit i (LSB first) selects item i: 0 = literal (1 byte), 1 = copy (2 bytes).
  - Copy byte0 = {len_m3[3:0], off[11:8]}; byte1 = off[7:0].
  - Copy length = len_m3 + 3 (3..18). Offset = distance back from the next write position (1..4095).
- States: CTRL_LO, CTRL_HI, ITEM, COPY_B1, COPY_RUN, FINISH.
  - CTRL_LO: accepts the control low byte, then goes to CTRL_HI.
  - CTRL_HI: accepts the control high byte; item index = 0; goes to ITEM.
  - ITEM, literal: accepts one byte, emits it, writes it to history.
  - ITEM, copy: latches byte0, then goes to COPY_B1.
  - COPY_B1: accepts byte1 and checks the offset.
    - Legal: go to COPY_RUN.
    - Illegal: pulse bad_item, emit nothing, go to the next item.
  - COPY_RUN: emits length bytes at one per cycle, each read from wp - off and written at wp.
  - After each item: index++. Index 16 → CTRL_LO.
- Legal offset: off != 0 and off <= hist_fill.
  - hist_fill = bytes written in the current stream, saturating at 2^HIST_AW - 1.
- Overlapping copies (off < len) must reproduce repeated bytes, e.g. off = 1 → run-length fill.
- in_last accepted on any byte ends the stream:
  - Any remaining copy run completes first.
  - State then goes to FINISH, which pulses finished_cycle.
  - Next state is CTRL_LO with wp = 0 and hist_fill = 0; each stream's history is independent.
- in_last on a control byte: no further items are decoded.
- in_ready = 1 in CTRL_LO, CTRL_HI, ITEM and COPY_B1; 0 in COPY_RUN and FINISH.
- Byte-wide history arithmetic: wp and the read address are modulo 2^HIST_AW.

## Timing
- Reset values:
  - in_ready = 0 while reset is asserted; 1 in the first cycle after deassertion.
  - decompressed_byte = 0x00; out_valid = 0; finished_cycle = 0; bad_item = 0.
  - State = CTRL_LO; wp = 0; hist_fill = 0.
- Literal: accepted at cycle t → out_valid at t+1.
- Copy: byte1 accepted at t → first byte at t+2, then one byte per cycle, contiguous, for len cycles.
  - in_ready drops at t+1 and rises in the cycle after the last copy byte.
- bad_item is registered: pulses in the cycle after byte1 is accepted.
- finished_cycle: the cycle after the final out_valid, or the cycle after the in_last handshake if no output is pending. Never coincident with out_valid.
- in_valid while in_ready = 0 is ignored; no data is lost, because the source must hold.
- Asynchronous reset mid-copy: all outputs clear immediately and the partial stream is discarded.

## Structure
- Package lzrw1_pkg holds:
  - The state enum.
  - Constants MIN_MATCH = 3, MAX_MATCH = 18, ITEMS_PER_GROUP = 16, OFF_W = 12.
- Sub-module lzrw1_hist_ram:
  - 2^HIST_AW x 8, one write port and one synchronous read port.
  - Write-first on read-during-write to the same address; this makes off = 1 correct.
  - Not reset.

## Test plan
- Reset: hold reset = 0 for 3 cycles → all outputs 0; in_ready = 1 in the first cycle after release.
- Literals: 0x00, 0x00, 0x41, 0x42, 0x43 (in_last on 0x43) → out 41, 42, 43, each one cycle after accept; finished_cycle the cycle after 43.
- Overlap copy: 0x02, 0x00, 0x61, 0x20, 0x01 (last) → 61, then five 61s starting 2 cycles after 0x01; in_ready low for those 5 cycles; then finished_cycle.
- Group wrap: control 0x0000, 16 literals 0x00..0x0F, control 0x0000, literal 0xAA (last) → 17 bytes out, in order.
- Illegal offset: 0x01, 0x00, 0x00, 0x05 (last) → bad_item pulse, zero out_valid, then finished_cycle.
- Reset mid-run: drop reset during the copy above → outputs 0 at once; a fresh literal stream 0x00, 0x00, 0x7E (last) → out 7E.

Source files
------------

// File: rtl/lzrw1_pkg.sv
// ---------------------------------------------------------------------------
// lzrw1_pkg
// Shared types and constants for the LZRW1 decompressor:
//   state_t          - decoder FSM states
//   MIN_MATCH        - shortest copy length (len_m3 = 0)
//   MAX_MATCH        - longest copy length (len_m3 = 15)
//   ITEMS_PER_GROUP  - items covered by one 16-bit control word
//   OFF_W            - width of the copy offset field
// ---------------------------------------------------------------------------
package lzrw1_pkg;

  localparam int MIN_MATCH       = 3;
  localparam int MAX_MATCH       = 18;
  localparam int ITEMS_PER_GROUP = 16;
  localparam int OFF_W           = 12;

  typedef enum logic [2:0] {
    CTRL_LO,
    CTRL_HI,
    ITEM,
    COPY_B1,
    COPY_RUN,
    FINISH
  } state_t;

endpackage

// File: rtl/lzrw1_hist_ram.sv
// ---------------------------------------------------------------------------
// lzrw1_hist_ram
// History buffer: 2^AW x 8, one write port and one synchronous read port.
// A read that hits the address being written in the same cycle returns the
// new data, so a copy with offset 1 sees the byte it just produced.
// Ports:
//   clock    in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address, sampled every cycle
//   rd_data  out  registered read data
// ---------------------------------------------------------------------------
module lzrw1_hist_ram #(
  parameter int AW = 12
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [2**AW];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the array has no reset; a reset loop would prevent RAM inference,
  // and the decoder never reads a location before writing it in a stream.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (wr_en && (wr_addr == rd_addr)) rd_data <= wr_data;
    else                               rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/lzrw1_decompressor.sv
// ---------------------------------------------------------------------------
// lzrw1_decompressor
// Streaming LZRW1 decoder. Parses control words, literals and copy items,
// rebuilds the original bytes in a history buffer and emits them one per
// cycle. Input flow control via in_ready; no output backpressure.
// Ports:
//   clock              in   sole clock, posedge
//   reset              in   asynchronous, active-low
//   in_valid/in_ready  in/out  byte handshake
//   in_byte            in   compressed stream byte
//   in_last            in   final byte of the compressed stream
//   decompressed_byte  out  reconstructed byte
//   out_valid          out  decompressed_byte valid
//   finished_cycle     out  one-cycle end-of-stream pulse
//   bad_item           out  one-cycle pulse for an illegal copy offset
// ---------------------------------------------------------------------------
module lzrw1_decompressor
  import lzrw1_pkg::*;
#(
  parameter int HIST_AW = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] decompressed_byte,
  output logic       out_valid,
  output logic       finished_cycle,
  output logic       bad_item
);

  localparam int RUN_W = $clog2(MAX_MATCH + 1);
  localparam int IDX_W = $clog2(ITEMS_PER_GROUP);

  state_t state, state_nxt;

  logic               alive;       // low until the first edge after reset
  logic [15:0]        ctrl;
  logic [IDX_W-1:0]   idx;
  logic [7:0]         copy_b0;
  logic               last_seen;   // in_last arrived with the copy's byte1
  logic [HIST_AW-1:0] wp;
  logic [HIST_AW-1:0] hist_fill;
  logic [HIST_AW-1:0] rd_addr;
  logic [RUN_W-1:0]   run_left;    // copy reads still to issue
  logic               from_ram;    // current output byte comes from history
  logic [7:0]         lit_byte;
  logic [7:0]         ram_q;

  logic               fire;
  logic               is_copy;
  logic               last_item;
  logic [OFF_W-1:0]   copy_off;
  logic               off_ok;
  logic               lit_fire;
  logic               bad_fire;
  logic               run_done;
  logic               item_done;
  logic               hist_clear;
  logic               wr_en;
  logic [7:0]         wr_data;
  state_t             after_item;

  always_comb begin
    in_ready = alive && (state inside {CTRL_LO, CTRL_HI, ITEM, COPY_B1});
  end

  assign fire       = in_valid && in_ready;
  assign is_copy    = ctrl[idx];
  assign last_item  = (idx == IDX_W'(ITEMS_PER_GROUP - 1));
  assign after_item = last_item ? CTRL_LO : ITEM;
  assign copy_off   = {copy_b0[3:0], in_byte};
  assign off_ok     = (copy_off != '0) && (32'(copy_off) <= 32'(hist_fill));
  assign lit_fire   = fire && (state == ITEM) && !is_copy;
  assign bad_fire   = fire && (state == COPY_B1) && !off_ok;
  // The last read was issued last cycle; its byte is on the output now.
  assign run_done   = (state == COPY_RUN) && (run_left == '0);
  assign item_done  = lit_fire || bad_fire || run_done;
  // FINISH waits out a trailing literal so the pulse never overlaps data.
  assign hist_clear = (state == FINISH) && !out_valid;

  // Copy bytes are written back as they leave the RAM, literals on accept.
  assign wr_en             = lit_fire || from_ram;
  assign wr_data           = from_ram ? ram_q : in_byte;
  assign decompressed_byte = from_ram ? ram_q : lit_byte;
  assign finished_cycle    = hist_clear;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= CTRL_LO;
    else        state <= state_nxt;
  end

  // NOTE: the default assignment first keeps every path assigned, so no
  // latch is inferred for state_nxt.
  always_comb begin
    state_nxt = state;
    unique case (state)
      CTRL_LO:  if (fire) state_nxt = in_last ? FINISH : CTRL_HI;
      CTRL_HI:  if (fire) state_nxt = in_last ? FINISH : ITEM;
      ITEM: begin
        if (fire) begin
          if (in_last)      state_nxt = FINISH;
          else if (is_copy) state_nxt = COPY_B1;
          else              state_nxt = after_item;
        end
      end
      COPY_B1: begin
        if (fire) begin
          if (off_ok)       state_nxt = COPY_RUN;
          else if (in_last) state_nxt = FINISH;
          else              state_nxt = after_item;
        end
      end
      COPY_RUN: if (run_done)   state_nxt = last_seen ? FINISH : after_item;
      FINISH:   if (hist_clear) state_nxt = CTRL_LO;
      default:  state_nxt = CTRL_LO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alive     <= 1'b0;
      ctrl      <= '0;
      idx       <= '0;
      copy_b0   <= '0;
      last_seen <= 1'b0;
      wp        <= '0;
      hist_fill <= '0;
      rd_addr   <= '0;
      run_left  <= '0;
      from_ram  <= 1'b0;
      lit_byte  <= '0;
      out_valid <= 1'b0;
      bad_item  <= 1'b0;
    end else begin
      alive     <= 1'b1;
      out_valid <= 1'b0;
      from_ram  <= 1'b0;
      bad_item  <= 1'b0;

      if (fire && (state == CTRL_LO)) ctrl[7:0]  <= in_byte;
      if (fire && (state == CTRL_HI)) ctrl[15:8] <= in_byte;
      if (fire && (state == ITEM) && is_copy) copy_b0 <= in_byte;

      if (lit_fire) begin
        lit_byte  <= in_byte;
        out_valid <= 1'b1;
      end

      if (fire && (state == COPY_B1)) begin
        last_seen <= in_last;
        if (off_ok) begin
          rd_addr  <= wp - HIST_AW'(copy_off);
          run_left <= RUN_W'(copy_b0[7:4]) + RUN_W'(MIN_MATCH);
        end else begin
          bad_item <= 1'b1;
        end
      end

      if ((state == COPY_RUN) && (run_left != '0)) begin
        rd_addr   <= rd_addr + 1'b1;
        run_left  <= run_left - 1'b1;
        out_valid <= 1'b1;
        from_ram  <= 1'b1;
      end

      if (fire && (state == CTRL_HI)) idx <= '0;
      else if (item_done)             idx <= idx + 1'b1;

      if (hist_clear) begin
        wp        <= '0;
        hist_fill <= '0;
      end else if (wr_en) begin
        wp <= wp + 1'b1;
        if (hist_fill != '1) hist_fill <= hist_fill + 1'b1;
      end
    end
  end

  lzrw1_hist_ram #(
    .AW(HIST_AW)
  ) u_hist (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wp),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

endmodule

// File: tb/tb_lzrw1_decompressor.sv
// ---------------------------------------------------------------------------
// tb_lzrw1_decompressor
// Directed bench for lzrw1_decompressor. Inputs change on the falling edge,
// outputs are sampled on the falling edge (mid-cycle).
// ---------------------------------------------------------------------------
module tb_lzrw1_decompressor;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_last;
  logic       in_ready;
  logic [7:0] decompressed_byte;
  logic       out_valid;
  logic       finished_cycle;
  logic       bad_item;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  lzrw1_decompressor #(
    .HIST_AW(12)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_byte           (in_byte),
    .in_last           (in_last),
    .in_ready          (in_ready),
    .decompressed_byte (decompressed_byte),
    .out_valid         (out_valid),
    .finished_cycle    (finished_cycle),
    .bad_item          (bad_item)
  );

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Present one byte for one cycle; returns at the falling edge after it.
  task automatic send(input logic [7:0] b, input logic l);
    check_bit("in_ready_before_send", in_ready, 1'b1);
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = l;
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] b);
    check_bit(tag, out_valid, 1'b1);
    check_byte(tag, decompressed_byte, b);
    check_bit("no_finish_with_data", finished_cycle, 1'b0);
  endtask

  task automatic expect_finish(input string tag);
    check_bit(tag, finished_cycle, 1'b1);
    check_bit("finish_no_data", out_valid, 1'b0);
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    in_last  = 1'b0;

    // Reset held for three cycles.
    repeat (3) @(negedge clock);
    check_bit("rst_in_ready", in_ready, 1'b0);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_byte("rst_byte", decompressed_byte, 8'h00);
    check_bit("rst_finished", finished_cycle, 1'b0);
    check_bit("rst_bad", bad_item, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    check_bit("ready_after_release", in_ready, 1'b1);

    // Literals 41 42 43, last on 43.
    send(8'h00, 1'b0);
    check_bit("lit_ctrl_quiet", out_valid, 1'b0);
    send(8'h00, 1'b0);
    send(8'h41, 1'b0); expect_out("lit_41", 8'h41);
    send(8'h42, 1'b0); expect_out("lit_42", 8'h42);
    send(8'h43, 1'b1); expect_out("lit_43", 8'h43);
    @(negedge clock);  expect_finish("lit_finish");
    @(negedge clock);  check_bit("lit_finish_one_cycle", finished_cycle, 1'b0);

    // Overlapping copy, off 1, len 5.
    send(8'h02, 1'b0);
    send(8'h00, 1'b0);
    send(8'h61, 1'b0); expect_out("ovl_lit", 8'h61);
    send(8'h20, 1'b0); check_bit("ovl_b0_quiet", out_valid, 1'b0);
    send(8'h01, 1'b1);
    check_bit("ovl_ready_drop", in_ready, 1'b0);
    check_bit("ovl_gap", out_valid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      expect_out("ovl_run", 8'h61);
      check_bit("ovl_ready_low", in_ready, 1'b0);
    end
    @(negedge clock);  expect_finish("ovl_finish");
    @(negedge clock);

    // Copy with off 2, len 3 over "AB" -> A B A.
    send(8'h04, 1'b0);
    send(8'h00, 1'b0);
    send(8'h41, 1'b0); expect_out("off2_lit_a", 8'h41);
    send(8'h42, 1'b0); expect_out("off2_lit_b", 8'h42);
    send(8'h00, 1'b0);
    send(8'h02, 1'b1);
    @(negedge clock);  expect_out("off2_c0", 8'h41);
    @(negedge clock);  expect_out("off2_c1", 8'h42);
    @(negedge clock);  expect_out("off2_c2", 8'h41);
    @(negedge clock);  expect_finish("off2_finish");
    @(negedge clock);

    // Group wrap: 16 literals, second control word, one more literal.
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 1'b0);
      expect_out("grp_lit", 8'(i));
    end
    send(8'h00, 1'b0); check_bit("grp_ctrl_quiet", out_valid, 1'b0);
    send(8'h00, 1'b0);
    send(8'hAA, 1'b1); expect_out("grp_aa", 8'hAA);
    @(negedge clock);  expect_finish("grp_finish");
    @(negedge clock);

    // Offset boundary: fill = 1, off 2 illegal then off 1 legal.
    send(8'h06, 1'b0);
    send(8'h00, 1'b0);
    send(8'h58, 1'b0); expect_out("fill_lit", 8'h58);
    send(8'h00, 1'b0);
    send(8'h02, 1'b0);
    check_bit("fill_bad_pulse", bad_item, 1'b1);
    check_bit("fill_bad_no_out", out_valid, 1'b0);
    send(8'h00, 1'b0);
    check_bit("fill_bad_one_cycle", bad_item, 1'b0);
    send(8'h01, 1'b1);
    check_bit("fill_good_not_bad", bad_item, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      expect_out("fill_run", 8'h58);
    end
    @(negedge clock);  expect_finish("fill_finish");
    @(negedge clock);

    // Illegal offset on an empty history, last on byte1.
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h05, 1'b1);
    check_bit("ill_bad_pulse", bad_item, 1'b1);
    expect_finish("ill_finish");
    @(negedge clock);
    check_bit("ill_bad_clear", bad_item, 1'b0);
    check_bit("ill_no_out", out_valid, 1'b0);
    check_bit("ill_finish_clear", finished_cycle, 1'b0);

    // Reset asserted in the middle of a copy run.
    send(8'h02, 1'b0);
    send(8'h00, 1'b0);
    send(8'h61, 1'b0); expect_out("mid_lit", 8'h61);
    send(8'h20, 1'b0);
    send(8'h01, 1'b1);
    @(negedge clock);  expect_out("mid_run0", 8'h61);
    @(negedge clock);  expect_out("mid_run1", 8'h61);
    #2 reset = 1'b0;
    #1;
    check_bit("mid_rst_valid", out_valid, 1'b0);
    check_byte("mid_rst_byte", decompressed_byte, 8'h00);
    check_bit("mid_rst_ready", in_ready, 1'b0);
    check_bit("mid_rst_finished", finished_cycle, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_bit("mid_ready_after_release", in_ready, 1'b1);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h7E, 1'b1); expect_out("fresh_7e", 8'h7E);
    @(negedge clock);  expect_finish("fresh_finish");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
